bram_fifo_ctrl: RTL
===================

// Module: bram_fifo_ctrl
// PURPOSE
//  Turns the 16x8 dual-port block RAM into a first-word-fall-through byte FIFO.
//  Sits directly upstream of the RAM and drives its write and read ports (w_en/w_addr/w_data, r_en/r_addr).
//  Accepts a valid/ready byte stream on the input side and presents a valid/ready stream on the output side.
//  The top level wires ram_* ports to the RAM instance; this block does not instantiate the RAM.
// PARAMETERS
//  ADDR_W  4  RAM address width; RAM depth = 2**ADDR_W
//  DATA_W  8  data width; must match RAM width
// PORTS
//  clk         in   1         system clock (12 MHz on board)
//  rst         in   1         asynchronous, active-high reset
//  in_data     in   DATA_W    write-side data
//  in_valid    in   1         write-side data valid
//  in_ready    out  1         write-side ready (= !full)
//  out_data    out  DATA_W    head-of-FIFO data (output register)
//  out_valid   out  1         out_data holds a valid word
//  out_ready   in   1         consumer accepts out_data this cycle
//  level       out  ADDR_W+1  words held (RAM + output register), 0..2**ADDR_W+1
//  ovf         out  1         sticky overflow flag (see CONFIGURATION)
//  ram_w_en    out  1         RAM write enable
//  ram_w_addr  out  ADDR_W    RAM write address
//  ram_w_data  out  DATA_W    RAM write data
//  ram_r_en    out  1         RAM read enable
//  ram_r_addr  out  ADDR_W    RAM read address
//  ram_r_data  in   DATA_W    RAM read data, registered, valid 1 clk after ram_r_en
// BEHAVIOUR
//  - Reset (async, rst=1): wr_ptr=rd_ptr=0, state=IDLE, out_valid=0, out_data=0, level=0, ovf=0,
//    in_ready=1, ram_w_en=ram_r_en=0.
//    Reset mid-operation discards all contents. RAM contents are untouched but unreachable.
//  - Pointers: wr_ptr and rd_ptr are ADDR_W+1 bits; the low ADDR_W bits address the RAM and wrap 15->0.
//    ram_cnt = wr_ptr - rd_ptr (modulo 2**(ADDR_W+1)).
//    full = (ram_cnt == 2**ADDR_W); ram_empty = (ram_cnt == 0).
//  - Write: push = in_valid & in_ready.
//    ram_w_en = push (combinational), ram_w_addr = wr_ptr[ADDR_W-1:0], ram_w_data = in_data.
//    wr_ptr increments on push.
//  - Prefetch FSM (states IDLE, FETCH, VALID):
//    IDLE : out_valid=0. If !ram_empty: ram_r_en=1, ram_r_addr=rd_ptr, rd_ptr++, go FETCH.
//    FETCH: out_valid=0. out_data <= ram_r_data, go VALID.
//    VALID: out_valid=1. Pop = out_ready.
//           On pop with !ram_empty: issue read as in IDLE, go FETCH.
//           On pop with ram_empty: go IDLE.
//           With no pop: hold out_data and stay in VALID.
//  - Latency: a write into an empty FIFO appears on out_valid 3 clks after the push edge
//    (1 clk RAM write, 1 clk read issue, 1 clk capture).
//    Sustained drain rate is 1 word per 2 clks.
//  - Simultaneous push and read issue are allowed. A read only issues when ram_cnt>0, so read and write
//    addresses never collide in the same cycle; full blocks writes.
//  - The ram_cnt used for a read issue is the registered value; a same-cycle push is not visible until the next cycle.
//  - level = ram_cnt + (state!=IDLE).
//    A word counts in level from the cycle after its push until the cycle after its pop.
//  - Push while full is ignored: in_ready=0 and pointers are unchanged.
// CONFIGURATION
//  FIFO_OVF_FLAG_EN defined:
//    ovf is set on any cycle with in_valid=1 & in_ready=0, and stays set until rst.
//  FIFO_OVF_FLAG_EN undefined:
//    ovf is tied to 0, the port is kept, and no flag register is built.
// STRUCTURE
//  Shared defs file bram_fifo_defs.vh holds:
//    - localparam state encodings ST_IDLE=2'd0, ST_FETCH=2'd1, ST_VALID=2'd2
//    - default ADDR_W/DATA_W values
//  One sub-module: bram_fifo_prefetch, containing the FSM, the output register and ram_r_en/rd_ptr advance.
//  The top-level bram_fifo_ctrl keeps the write pointer, level and ovf.
// TESTING (bench pairs this block with the 16x8 block RAM, mem_init ignored)
//  1. rst pulse mid-stream after 5 pushes -> level=0, out_valid=0, in_ready=1 immediately (async); next push reads back first.
//  2. push 0x11, out_ready=0 -> out_valid=1 and out_data=0x11 on the 3rd edge after the push; level=1; holds indefinitely.
//  3. push 0x00..0x10 (17 words), out_ready=0 -> in_ready=0 after 17th accepted; level=17; pop all -> 0x00..0x10 in order.
//  4. fill to full, hold in_valid=1 with 0xEE -> word dropped, pointers unchanged; ovf=1 with FIFO_OVF_FLAG_EN, 0 without.
//  5. continuous push 0xA0.. with out_ready=1 for 40 clks -> no loss, ordered output, write address wraps 15->0 at least twice.
//  6. push 0x5A and 0xA5 on consecutive clks from empty, out_ready=1 -> 0x5A then 0xA5, out_valid low exactly 1 clk between.

Source files
------------

// File: rtl/bram_fifo_pkg.sv
// Shared definitions for the block-RAM FWFT FIFO controller: default widths and prefetch state encoding.
package bram_fifo_pkg;

    localparam int ADDR_W_DEF = 4;
    localparam int DATA_W_DEF = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_VALID = 2'd2
    } state_e;

endpackage

// File: rtl/bram_fifo_prefetch.sv
// Prefetch engine: pulls the head word out of the block RAM into the output register
// and presents it as a first-word-fall-through valid/ready stream.
//
//  state    | meaning
//  ---------+-----------------------------------------------------------
//  ST_IDLE  | output register empty, no read in flight
//  ST_FETCH | read issued last cycle, RAM data arrives this cycle
//  ST_VALID | output register holds the head word (out_valid_o=1)
module bram_fifo_prefetch
    import bram_fifo_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              ram_empty_i,
    input  logic              out_ready_i,
    input  logic [DATA_W-1:0] ram_r_data_i,
    output logic [DATA_W-1:0] out_data_o,
    output logic              out_valid_o,
    output logic              busy_o,
    output logic              ram_r_en_o,
    output logic [ADDR_W-1:0] ram_r_addr_o,
    output logic [ADDR_W:0]   rd_ptr_o
);

    state_e              state_q, state_d;
    logic [ADDR_W:0]     rd_ptr_q, rd_ptr_d;
    logic [DATA_W-1:0]   data_q, data_d;
    logic                rd_issue;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q  <= ST_IDLE;
            rd_ptr_q <= '0;
            data_q   <= '0;
        end else begin
            state_q  <= state_d;
            rd_ptr_q <= rd_ptr_d;
            data_q   <= data_d;
        end
    end

    // ram_empty_i comes from registered pointers, so a push in this same cycle is not yet visible.
    always_comb begin
        state_d  = state_q;
        rd_ptr_d = rd_ptr_q;
        data_d   = data_q;
        rd_issue = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (!ram_empty_i) begin
                    rd_issue = 1'b1;
                    state_d  = ST_FETCH;
                end
            end
            ST_FETCH: begin
                data_d  = ram_r_data_i;
                state_d = ST_VALID;
            end
            ST_VALID: begin
                if (out_ready_i) begin
                    if (!ram_empty_i) begin
                        rd_issue = 1'b1;
                        state_d  = ST_FETCH;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
        if (rd_issue) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
    end

    assign out_data_o   = data_q;
    assign out_valid_o  = (state_q == ST_VALID);
    assign busy_o       = (state_q != ST_IDLE);
    assign ram_r_en_o   = rd_issue;
    assign ram_r_addr_o = rd_ptr_q[ADDR_W-1:0];
    assign rd_ptr_o     = rd_ptr_q;

endmodule

// File: rtl/bram_fifo_ctrl.sv
// First-word-fall-through byte FIFO controller driving an external dual-port block RAM.
// Optional sticky overflow flag built only when FIFO_OVF_FLAG_EN is defined.
module bram_fifo_ctrl
    import bram_fifo_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [DATA_W-1:0] in_data_i,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    output logic [DATA_W-1:0] out_data_o,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic [ADDR_W:0]   level_o,
    output logic              ovf_o,
    output logic              ram_w_en_o,
    output logic [ADDR_W-1:0] ram_w_addr_o,
    output logic [DATA_W-1:0] ram_w_data_o,
    output logic              ram_r_en_o,
    output logic [ADDR_W-1:0] ram_r_addr_o,
    input  logic [DATA_W-1:0] ram_r_data_i
);

    localparam logic [ADDR_W:0] RAM_DEPTH = {1'b1, {ADDR_W{1'b0}}};

    logic [ADDR_W:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_W:0] rd_ptr;
    logic [ADDR_W:0] ram_cnt;
    logic            full;
    logic            ram_empty;
    logic            push;
    logic            busy;

    // Extra pointer bit distinguishes a full RAM from an empty one.
    assign ram_cnt   = wr_ptr_q - rd_ptr;
    assign full      = (ram_cnt == RAM_DEPTH);
    assign ram_empty = (ram_cnt == '0);

    assign in_ready_o   = !full;
    assign push         = in_valid_i & !full;
    assign ram_w_en_o   = push;
    assign ram_w_addr_o = wr_ptr_q[ADDR_W-1:0];
    assign ram_w_data_o = in_data_i;

    assign wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
        end
    end

    bram_fifo_prefetch #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_prefetch (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .ram_empty_i  (ram_empty),
        .out_ready_i  (out_ready_i),
        .ram_r_data_i (ram_r_data_i),
        .out_data_o   (out_data_o),
        .out_valid_o  (out_valid_o),
        .busy_o       (busy),
        .ram_r_en_o   (ram_r_en_o),
        .ram_r_addr_o (ram_r_addr_o),
        .rd_ptr_o     (rd_ptr)
    );

    // The output register counts as one held word whenever the prefetcher is not idle.
    assign level_o = ram_cnt + {{ADDR_W{1'b0}}, busy};

`ifdef FIFO_OVF_FLAG_EN
    logic ovf_q, ovf_d;

    assign ovf_d = ovf_q | (in_valid_i & full);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            ovf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
        end
    end

    assign ovf_o = ovf_q;
`else
    assign ovf_o = 1'b0;
`endif

endmodule
